// File: rtl/scfifo_stream_reader.sv
// Burst drain engine for a single-clock showahead FIFO, presented downstream as a valid/ready
// stream through a 2-entry skid buffer. Optional feature macro: SCFIFO_READER_LAST_EN (out_last).
module scfifo_stream_reader #(
    parameter int WIDTH         = 20,
    parameter int LOG_DEPTH     = 8,
    parameter int BURST_LEN     = 8,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic [WIDTH-1:0]     fifo_q,
    input  logic                 fifo_empty,
    input  logic                 fifo_almost_empty,
    input  logic [LOG_DEPTH-1:0] fifo_usedw,
    output logic                 fifo_rdreq,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);
    localparam int BEAT_W  = $clog2(BURST_LEN + 1);
    localparam int TIMER_W = $clog2(FLUSH_TIMEOUT);
    localparam logic [BEAT_W-1:0]  BEATS_FULL  = BEAT_W'(BURST_LEN);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [BEAT_W-1:0]  beats_q, beats_d;

    logic [WIDTH-1:0]   skid_data_q [2];
    logic [WIDTH-1:0]   skid_data_d [2];
    logic               skid_valid_q [2];
    logic               skid_valid_d [2];
    logic               skid_full;
    logic               skid_pop;
    logic               push_to_head;
    logic               final_pop;

    assign skid_full = skid_valid_q[0] && skid_valid_q[1];
    assign final_pop = fifo_rdreq && ((beats_q == BEAT_W'(1)) || (fifo_usedw == LOG_DEPTH'(1)));

    // ------------------------------------------------------------------
    // Burst FSM. The pop request depends only on state, skid occupancy,
    // FIFO emptiness and reset, so downstream ready never reaches rdreq.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        beats_d    = beats_q;
        fifo_rdreq = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                if (!fifo_almost_empty || (timer_q == TIMER_LIMIT)) begin
                    state_d = S_BURST;
                    beats_d = BEATS_FULL;
                end else if (fifo_empty) begin
                    state_d = S_IDLE;
                end else begin
                    // timer_q < TIMER_LIMIT here, so this never wraps
                    timer_d = timer_q + 1'b1;
                end
            end
            S_BURST: begin
                fifo_rdreq = !fifo_empty && !skid_full && !sclr;
                if (fifo_rdreq) begin
                    if (beats_q != '0) begin
                        beats_d = beats_q - 1'b1;
                    end
                    if (final_pop) begin
                        state_d = S_IDLE;
                    end
                end else if (fifo_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            beats_q <= beats_d;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer: entry 0 is the head. A pop shifts entry 1 forward, then
    // the showahead word lands in the first free slot.
    // ------------------------------------------------------------------
    always_comb begin
        skid_pop        = skid_valid_q[0] && out_ready;
        skid_valid_d[0] = skid_pop ? skid_valid_q[1] : skid_valid_q[0];
        skid_data_d[0]  = skid_pop ? skid_data_q[1]  : skid_data_q[0];
        skid_valid_d[1] = skid_pop ? 1'b0 : skid_valid_q[1];
        skid_data_d[1]  = skid_data_q[1];
        push_to_head    = !skid_valid_d[0];
        if (fifo_rdreq) begin
            if (push_to_head) begin
                skid_valid_d[0] = 1'b1;
                skid_data_d[0]  = fifo_q;
            end else begin
                skid_valid_d[1] = 1'b1;
                skid_data_d[1]  = fifo_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            for (int i = 0; i < 2; i++) begin
                skid_valid_q[i] <= 1'b0;
                skid_data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                skid_valid_q[i] <= skid_valid_d[i];
                skid_data_q[i]  <= skid_data_d[i];
            end
        end
    end

    assign out_data  = skid_data_q[0];
    assign out_valid = skid_valid_q[0];

`ifdef SCFIFO_READER_LAST_EN
    logic skid_last_q [2];
    logic skid_last_d [2];

    // Last flags follow their data words; a flag is cleared when its slot empties.
    always_comb begin
        skid_last_d[0] = skid_pop ? skid_last_q[1] : skid_last_q[0];
        skid_last_d[1] = skid_last_q[1];
        if (fifo_rdreq) begin
            if (push_to_head) begin
                skid_last_d[0] = final_pop;
            end else begin
                skid_last_d[1] = final_pop;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (!skid_valid_d[i]) begin
                skid_last_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            for (int i = 0; i < 2; i++) begin
                skid_last_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                skid_last_q[i] <= skid_last_d[i];
            end
        end
    end

    assign out_last = skid_last_q[0];
`else
    assign out_last = 1'b0;
`endif

endmodule
